// File: rtl/yuv422_to_444_seq.sv
// yuv422_to_444_seq: unpacks a 4:2:2 {Y,C} stream into 4:4:4 {Y,U,V} pixels
// with a fixed 2-clock latency. Even/odd samples are paired per line; the
// pair's Cb/Cr is held so the odd pixel reuses it, and vs/de are delayed to
// stay aligned with the data.
// Optional feature: define YUV422_STATS_EN to add line_cnt_o / err_o.
module yuv422_to_444_seq #(
  parameter int CB_FIRST = 1,
  parameter int DW       = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          vs_i,
  input  logic          de_i,
  input  logic [DW-1:0] y_i,
  input  logic [DW-1:0] c_i,
  output logic          vs_o,
  output logic          de_o,
  output logic [DW-1:0] y_o,
  output logic [DW-1:0] u_o,
  output logic [DW-1:0] v_o
`ifdef YUV422_STATS_EN
  ,
  output logic [11:0]   line_cnt_o,
  output logic          err_o
`endif
);

  // Mid-scale chroma: neutral value used when no real chroma is known yet.
  localparam logic [DW-1:0] MID = DW'(1) << (DW - 1);

  typedef enum logic [1:0] {IDLE, ODD_NEXT, EVEN_NEXT} state_t;

  state_t        state, state_nxt;
  logic          odd_in;

  logic          vs1, de1, odd1;
  logic [DW-1:0] y1, c1;

  logic [DW-1:0] held_cb, held_cr;
  logic [DW-1:0] pair_cb, pair_cr;
  logic [DW-1:0] u_nxt, v_nxt;
  logic          pair_now, line_end;

  // Phase tracker: classifies the incoming sample as even or odd in its line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next phase: a line always opens on an even sample, then alternates.
  always_comb begin
    odd_in    = 1'b0;
    state_nxt = IDLE;
    if (de_i) begin
      odd_in    = (state == ODD_NEXT);
      state_nxt = odd_in ? EVEN_NEXT : ODD_NEXT;
    end
  end

  // Stage 1: capture the sample together with its phase and sync flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vs1  <= 1'b0;
      de1  <= 1'b0;
      odd1 <= 1'b0;
      y1   <= '0;
      c1   <= '0;
    end else begin
      vs1  <= vs_i;
      de1  <= de_i;
      odd1 <= odd_in;
      y1   <= y_i;
      c1   <= c_i;
    end
  end

  // An even sample in stage 1 finds its odd partner on the live input.
  assign pair_now = de1 && !odd1 && de_i;
  assign line_end = de1 && !de_i;
  assign pair_cb  = (CB_FIRST != 0) ? c1  : c_i;
  assign pair_cr  = (CB_FIRST != 0) ? c_i : c1;

  // Chroma selection for the pixel leaving stage 1.
  always_comb begin
    u_nxt = u_o;
    v_nxt = v_o;
    if (de1) begin
      if (odd1) begin
        u_nxt = held_cb;
        v_nxt = held_cr;
      end else if (de_i) begin
        u_nxt = pair_cb;
        v_nxt = pair_cr;
      end else begin
        // Unpaired even sample: its own chroma is one component, the other
        // comes from the previous pair of the line (mid-scale on line start).
        u_nxt = (CB_FIRST != 0) ? c1 : held_cb;
        v_nxt = (CB_FIRST != 0) ? held_cr : c1;
      end
    end
  end

  // Held chroma: loaded from each completed pair, neutralised at line end.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      held_cb <= MID;
      held_cr <= MID;
    end else if (line_end) begin
      held_cb <= MID;
      held_cr <= MID;
    end else if (pair_now) begin
      held_cb <= pair_cb;
      held_cr <= pair_cr;
    end
  end

  // Stage 2: output registers; data holds its last value while de is low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vs_o <= 1'b0;
      de_o <= 1'b0;
      y_o  <= '0;
      u_o  <= '0;
      v_o  <= '0;
    end else begin
      vs_o <= vs1;
      de_o <= de1;
      if (de1) y_o <= y1;
      u_o <= u_nxt;
      v_o <= v_nxt;
    end
  end

`ifdef YUV422_STATS_EN
  logic vs_rise;
  assign vs_rise = vs_i && !vs1;

  // Line counter: counts de falling edges, cleared at each new frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      line_cnt_o <= '0;
    else if (vs_rise)  line_cnt_o <= '0;
    else if (line_end) line_cnt_o <= line_cnt_o + 12'd1;
  end

  // Sticky odd-width flag: a line ending on an even sample sets it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                err_o <= 1'b0;
    else if (line_end && !odd1)  err_o <= 1'b1;
    else if (vs_rise)            err_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_yuv422_to_444_seq.sv
// Bench for yuv422_to_444_seq: two instances (Cb-first and Cr-first) share
// one stimulus stream; a line-position model predicts every output cycle.
module tb_yuv422_to_444_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vs_i, de_i;
  logic [7:0] y_i, c_i;
  logic       vs0, de0, vs1, de1;
  logic [7:0] y0, u0, v0, y1, u1, v1;
`ifdef YUV422_STATS_EN
  logic [11:0] lc0, lc1;
  logic        er0, er1;
`endif

  always #5 clk = ~clk;

  yuv422_to_444_seq #(.CB_FIRST(1), .DW(8)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .vs_i(vs_i), .de_i(de_i), .y_i(y_i), .c_i(c_i),
    .vs_o(vs0), .de_o(de0), .y_o(y0), .u_o(u0), .v_o(v0)
`ifdef YUV422_STATS_EN
    , .line_cnt_o(lc0), .err_o(er0)
`endif
  );

  yuv422_to_444_seq #(.CB_FIRST(0), .DW(8)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .vs_i(vs_i), .de_i(de_i), .y_i(y_i), .c_i(c_i),
    .vs_o(vs1), .de_o(de1), .y_o(y1), .u_o(u1), .v_o(v1)
`ifdef YUV422_STATS_EN
    , .line_cnt_o(lc1), .err_o(er1)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Stimulus history (ring), with each sample's position within its line.
  bit         rvs [16];
  bit         rde [16];
  logic [7:0] ry  [16];
  logic [7:0] rc  [16];
  int         rpos[16];
  int         cyc  = 0;
  int         base = 0;

  logic [7:0] last_y [2];
  logic [7:0] last_u [2];
  logic [7:0] last_v [2];
  logic [23:0] got0[$];
  logic [23:0] got1[$];
  int   exp_cnt = 0;
  bit   exp_err = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected chroma of pixel j from its line position and neighbours.
  function automatic void model(input int j, input bit cbf,
                                output logic [7:0] u, output logic [7:0] v);
    int k;
    logic [7:0] ce, co;
    k = rpos[j & 15];
    if (k % 2 == 0) begin
      ce = rc[j & 15];
      if (rde[(j + 1) & 15]) co = rc[(j + 1) & 15];
      else                   co = (k >= 2) ? rc[(j - 1) & 15] : 8'd128;
    end else begin
      ce = rc[(j - 1) & 15];
      co = rc[j & 15];
    end
    u = cbf ? ce : co;
    v = cbf ? co : ce;
  endfunction

  task automatic drive(input bit v, input bit d, input logic [7:0] y, input logic [7:0] c);
    int idx, pidx;
    @(negedge clk);
    vs_i = v; de_i = d; y_i = y; c_i = c;
    idx  = cyc & 15;
    pidx = (cyc - 1) & 15;
    rvs[idx] = v; rde[idx] = d; ry[idx] = y; rc[idx] = c;
    rpos[idx] = !d ? -1 : ((cyc > 0 && rde[pidx]) ? rpos[pidx] + 1 : 0);
    cyc++;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic pix(input logic [23:0] g, input logic [7:0] y, input logic [7:0] u,
                     input logic [7:0] v, input string name);
    chk({name, ".y"}, int'(g[23:16]), int'(y));
    chk({name, ".u"}, int'(g[15:8]),  int'(u));
    chk({name, ".v"}, int'(g[7:0]),   int'(v));
  endtask

  task automatic check_zero(input string name);
    chk({name, ".vs0"}, int'(vs0), 0); chk({name, ".de0"}, int'(de0), 0);
    chk({name, ".y0"},  int'(y0),  0); chk({name, ".u0"},  int'(u0),  0);
    chk({name, ".v0"},  int'(v0),  0); chk({name, ".de1"}, int'(de1), 0);
    chk({name, ".u1"},  int'(u1),  0); chk({name, ".v1"},  int'(v1),  0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      last_y[d] = 8'd0; last_u[d] = 8'd0; last_v[d] = 8'd0;
    end
    exp_cnt = 0; exp_err = 1'b0;
    gap(3);
    rst_n = 1'b1;
    base  = cyc - 1;
  endtask

  // Per-cycle compare of both instances against the model.
  always @(posedge clk) begin
    int j;
    logic [7:0] eu, ev;
    #1;
    j = cyc - 2;
    if (rst_n && cyc >= 2 && j >= base) begin
      for (int d = 0; d < 2; d++) begin
        if (rde[j & 15]) begin
          model(j, (d == 0), eu, ev);
          last_y[d] = ry[j & 15]; last_u[d] = eu; last_v[d] = ev;
        end
      end
      chk("vs0", int'(vs0), int'(rvs[j & 15]));
      chk("de0", int'(de0), int'(rde[j & 15]));
      chk("y0",  int'(y0),  int'(last_y[0]));
      chk("u0",  int'(u0),  int'(last_u[0]));
      chk("v0",  int'(v0),  int'(last_v[0]));
      chk("vs1", int'(vs1), int'(rvs[j & 15]));
      chk("de1", int'(de1), int'(rde[j & 15]));
      chk("y1",  int'(y1),  int'(last_y[1]));
      chk("u1",  int'(u1),  int'(last_u[1]));
      chk("v1",  int'(v1),  int'(last_v[1]));
      if (de0) got0.push_back({y0, u0, v0});
      if (de1) got1.push_back({y1, u1, v1});
    end
`ifdef YUV422_STATS_EN
    if (rst_n && cyc >= 2 && cyc - 1 >= base) begin
      int i, p;
      bit rise, fall;
      i = (cyc - 1) & 15; p = (cyc - 2) & 15;
      rise = rvs[i] && !rvs[p];
      fall = rde[p] && !rde[i];
      if (rise)      exp_cnt = 0;
      else if (fall) exp_cnt = (exp_cnt + 1) % 4096;
      if (fall && (rpos[p] % 2 == 0)) exp_err = 1'b1;
      else if (rise)                  exp_err = 1'b0;
      chk("line_cnt0", int'(lc0), exp_cnt);
      chk("err0",      int'(er0), int'(exp_err));
      chk("line_cnt1", int'(lc1), exp_cnt);
      chk("err1",      int'(er1), int'(exp_err));
    end
`endif
  end

  initial begin
    rst_n = 1'b0; vs_i = 1'b0; de_i = 1'b0; y_i = 8'd0; c_i = 8'd0;
    @(negedge clk);
    check_zero("reset");
    do_reset();
    gap(2);

    // Four-pixel Cb-first line.
    got0.delete(); got1.delete();
    drive(0, 1, 8'd10, 8'd20); drive(0, 1, 8'd11, 8'd30);
    drive(0, 1, 8'd12, 8'd40); drive(0, 1, 8'd13, 8'd50);
    gap(4);
    chk("line4.count", got0.size(), 4);
    if (got0.size() == 4) begin
      pix(got0[0], 8'd10, 8'd20, 8'd30, "line4.p0");
      pix(got0[1], 8'd11, 8'd20, 8'd30, "line4.p1");
      pix(got0[2], 8'd12, 8'd40, 8'd50, "line4.p2");
      pix(got0[3], 8'd13, 8'd40, 8'd50, "line4.p3");
    end

    // Odd width 3, then a single-pixel line.
    got0.delete();
    drive(0, 1, 8'd10, 8'd20); drive(0, 1, 8'd11, 8'd30); drive(0, 1, 8'd12, 8'd40);
    gap(2);
    drive(0, 1, 8'd5, 8'd60);
    gap(4);
    chk("odd.count", got0.size(), 4);
    if (got0.size() == 4) begin
      pix(got0[2], 8'd12, 8'd40, 8'd30, "odd3.p2");
      pix(got0[3], 8'd5,  8'd60, 8'd128, "one.p0");
    end

    // Cr-first pair on the second instance.
    got1.delete();
    drive(0, 1, 8'd10, 8'd70); drive(0, 1, 8'd11, 8'd80);
    gap(4);
    chk("crfirst.count", got1.size(), 2);
    if (got1.size() == 2) begin
      pix(got1[0], 8'd10, 8'd80, 8'd70, "crfirst.p0");
      pix(got1[1], 8'd11, 8'd80, 8'd70, "crfirst.p1");
    end

    // Back-to-back lines with a one-clock gap; vs high across a line start.
    got0.delete();
    drive(0, 1, 8'd1, 8'd100); drive(0, 1, 8'd2, 8'd110); drive(0, 1, 8'd3, 8'd120);
    drive(1, 0, 8'd0, 8'd0);
    drive(1, 1, 8'd4, 8'd130);
    gap(4);
    chk("b2b.count", got0.size(), 4);
    if (got0.size() == 4) pix(got0[3], 8'd4, 8'd130, 8'd128, "b2b.p0");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), 8'($urandom));
    gap(3);

    // Reset in the middle of a line; next line must start even.
    drive(0, 1, 8'd33, 8'd44); drive(0, 1, 8'd34, 8'd45); drive(0, 1, 8'd35, 8'd46);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    do_reset();
    got0.delete();
    drive(0, 1, 8'd7, 8'd90); drive(0, 1, 8'd8, 8'd91);
    gap(4);
    chk("postrst.count", got0.size(), 2);
    if (got0.size() == 2) begin
      pix(got0[0], 8'd7, 8'd90, 8'd91, "postrst.p0");
      pix(got0[1], 8'd8, 8'd90, 8'd91, "postrst.p1");
    end

`ifdef YUV422_STATS_EN
    drive(1, 0, 8'd0, 8'd0); gap(1);
    drive(0, 1, 8'd1, 8'd1); drive(0, 1, 8'd2, 8'd2); gap(1);
    drive(0, 1, 8'd3, 8'd3); drive(0, 1, 8'd4, 8'd4); gap(1);
    drive(0, 1, 8'd5, 8'd5); drive(0, 1, 8'd6, 8'd6); drive(0, 1, 8'd7, 8'd7); gap(1);
    @(posedge clk); #2;
    chk("stats.cnt3", int'(lc0), 3);
    chk("stats.err1", int'(er0), 1);
    drive(1, 0, 8'd0, 8'd0);
    @(posedge clk); #2;
    chk("stats.cnt0", int'(lc0), 0);
    chk("stats.err0", int'(er0), 0);
    gap(1);
    for (int i = 0; i < 4096; i++) begin
      drive(0, 1, 8'd9, 8'd9); gap(1);
    end
    @(posedge clk); #2;
    chk("stats.wrap", int'(lc0), 0);
    chk("stats.errw", int'(er0), 1);
`endif

    gap(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
